// File: rtl/invader_timer_pkg.sv
// Shared constants and state encoding for the invader step timer.
// Optional speed-up is enabled with the INVADER_SPEEDUP_EN macro.
package invader_timer_pkg;

  localparam int DEF_CNT_W        = 20;
  localparam int DEF_PERIOD       = 500000;
  localparam int DEF_MIN_PERIOD   = 20000;
  localparam int DEF_SPEEDUP_STEP = 5000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

endpackage

// File: rtl/invader_period_reg.sv
// Period latch with saturating per-kill speed-up.
// The speed-up path exists only when INVADER_SPEEDUP_EN is defined.
module invader_period_reg
  import invader_timer_pkg::*;
#(
  parameter int CNT_W          = DEF_CNT_W,
  parameter int DEFAULT_PERIOD = DEF_PERIOD,
  parameter int MIN_PERIOD     = DEF_MIN_PERIOD,
  parameter int SPEEDUP_STEP   = DEF_SPEEDUP_STEP
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic             kill_i,
  output logic [CNT_W-1:0] period_o
);

  localparam logic [CNT_W-1:0] DEF_P  = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] MIN_P  = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] STEP_P = CNT_W'(SPEEDUP_STEP);

  logic [CNT_W-1:0] period_q, period_d;

`ifdef INVADER_SPEEDUP_EN
  logic [CNT_W-1:0] dec;

  always_comb begin
    // saturate at zero first so the floor compare never sees a wrapped value
    dec      = (period_q > STEP_P) ? (period_q - STEP_P) : '0;
    period_d = period_q;
    if (load_i)      period_d = period_i;
    else if (kill_i) period_d = (dec < MIN_P) ? MIN_P : dec;
  end
`else
  logic unused_kill;
  assign unused_kill = kill_i | (|MIN_P) | (|STEP_P);

  always_comb begin
    period_d = period_q;
    if (load_i) period_d = period_i;
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) period_q <= DEF_P;
    else       period_q <= period_d;
  end

  assign period_o = period_q;

endmodule

// File: rtl/invader_step_timer.sv
// Microsecond-tick down-counter emitting a one-cycle step strobe on expiry.
// Kill-driven speed-up is compiled in with INVADER_SPEEDUP_EN.
//
// state    | meaning
// ST_IDLE  | not counting, remaining held at 0
// ST_RUN   | counting ticks down toward expiry
// ST_PAUSE | count frozen until pause drops
module invader_step_timer
  import invader_timer_pkg::*;
#(
  parameter int CNT_W          = DEF_CNT_W,
  parameter int DEFAULT_PERIOD = DEF_PERIOD,
  parameter int MIN_PERIOD     = DEF_MIN_PERIOD,
  parameter int SPEEDUP_STEP   = DEF_SPEEDUP_STEP
) (
  input  logic             clk_36MHz,
  input  logic             reset,
  input  logic             tick_1us,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             periodic,
  input  logic [CNT_W-1:0] period_us,
  input  logic             kill,
  output logic             busy,
  output logic             step,
  output logic [CNT_W-1:0] remaining,
  output logic [7:0]       step_count
);

  state_e           state_q, state_d;
  logic             busy_q;
  logic [CNT_W-1:0] rem_q, rem_d, period_reg, start_val;
  logic             mode_q, mode_d, step_q, step_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             do_start, run_tick, expire;

  assign do_start  = start & ~stop;
  assign start_val = (period_us == '0) ? CNT_W'(1) : period_us;
  assign run_tick  = (state_q == ST_RUN) & ~pause & tick_1us & ~stop & ~start;
  // an expiring tick right after a step is held off so step never doubles up
  assign expire    = run_tick & (rem_q == CNT_W'(1)) & ~step_q;

  invader_period_reg #(
    .CNT_W          (CNT_W),
    .DEFAULT_PERIOD (DEFAULT_PERIOD),
    .MIN_PERIOD     (MIN_PERIOD),
    .SPEEDUP_STEP   (SPEEDUP_STEP)
  ) u_period (
    .clk_i    (clk_36MHz),
    .rst_i    (reset),
    .load_i   (do_start),
    .period_i (start_val),
    .kill_i   (kill & ~start),
    .period_o (period_reg)
  );

  always_ff @(posedge clk_36MHz or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    if (stop)       state_d = ST_IDLE;
    else if (start) state_d = ST_RUN;
    else begin
      case (state_q)
        ST_RUN: begin
          if (pause)                 state_d = ST_PAUSE;
          else if (expire && !mode_q) state_d = ST_IDLE;
        end
        ST_PAUSE: if (!pause) state_d = ST_RUN;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    rem_d  = rem_q;
    mode_d = mode_q;
    cnt_d  = cnt_q;
    step_d = 1'b0;
    if (stop) begin
      rem_d = '0;
    end else if (start) begin
      rem_d  = start_val;
      mode_d = periodic;
      cnt_d  = '0;
    end else if (expire) begin
      step_d = 1'b1;
      cnt_d  = cnt_q + 8'd1;
      rem_d  = mode_q ? period_reg : '0;
    end else if (run_tick && rem_q > CNT_W'(1)) begin
      rem_d = rem_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_36MHz or posedge reset) begin
    if (reset) begin
      rem_q  <= '0;
      mode_q <= 1'b0;
      cnt_q  <= '0;
      step_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      step_q <= step_d;
    end
  end

  assign busy       = busy_q;
  assign step       = step_q;
  assign remaining  = rem_q;
  assign step_count = cnt_q;

endmodule

// File: tb/tb_invader_step_timer.sv
// Self-checking bench for invader_step_timer; build with and without INVADER_SPEEDUP_EN.
module tb_invader_step_timer;

  localparam int CNT_W        = 20;
  localparam int DEF_PERIOD   = 500000;
  localparam int MIN_PERIOD   = 20000;
  localparam int SPEEDUP_STEP = 5000;
`ifdef INVADER_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1;
  logic tick = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0, periodic = 1'b0, kill = 1'b0;
  logic [CNT_W-1:0] period_us = '0;
  logic busy, step;
  logic [CNT_W-1:0] remaining;
  logic [7:0] step_count;

  int n_cmp = 0, n_err = 0;

  // reference model: timer seen as "active / paused / ticks left / period"
  bit m_run, m_pau, m_mode, m_step;
  int m_rem, m_per, m_cnt;

  always #5 clk = ~clk;

  invader_step_timer dut (
    .clk_36MHz (clk), .reset (reset), .tick_1us (tick), .start (start),
    .stop (stop), .pause (pause), .periodic (periodic), .period_us (period_us),
    .kill (kill), .busy (busy), .step (step), .remaining (remaining),
    .step_count (step_count)
  );

  task automatic model_reset();
    m_run = 0; m_pau = 0; m_mode = 0; m_step = 0;
    m_rem = 0; m_cnt = 0; m_per = DEF_PERIOD;
  endtask

  task automatic model_cycle();
    int per_old;
    bit s;
    per_old = m_per;
    s = 0;
    if (stop) begin
      m_run = 0; m_pau = 0; m_rem = 0;
    end else if (start) begin
      m_per = (period_us == 0) ? 1 : int'(period_us);
      m_rem = m_per; m_mode = periodic; m_cnt = 0; m_run = 1; m_pau = 0;
    end else if (m_run && m_pau) begin
      if (!pause) m_pau = 0;
    end else if (m_run) begin
      if (pause) m_pau = 1;
      else if (tick) begin
        if (m_rem > 1) m_rem = m_rem - 1;
        else if (!m_step) begin
          s = 1;
          m_cnt = (m_cnt + 1) % 256;
          if (m_mode) m_rem = per_old;
          else begin m_rem = 0; m_run = 0; end
        end
      end
    end
    if (SPEEDUP && kill && !start)
      m_per = (per_old - SPEEDUP_STEP < MIN_PERIOD) ? MIN_PERIOD : per_old - SPEEDUP_STEP;
    m_step = s;
  endtask

  task automatic cyc();
    model_cycle();
    @(posedge clk); #1;
    start = 0; stop = 0; kill = 0; tick = 0;
  endtask

  task automatic wait_tick(input int spacing);
    repeat (spacing - 1) cyc();
    tick = 1;
    cyc();
  endtask

  task automatic test_reset();
    #1;
    model_reset();
    n_cmp++;
    if ({busy, step, remaining, step_count} !== '0) begin
      n_err++; $display("FAIL reset_init: got busy=%0b step=%0b rem=%0d cnt=%0d want all 0", busy, step, remaining, step_count);
    end
    @(posedge clk); #1; reset = 0;
    periodic = 1; period_us = 6; start = 1; cyc();
    repeat (8) begin tick = 1; cyc(); end
    n_cmp++;
    if (step_count !== 8'(m_cnt) || remaining !== CNT_W'(m_rem)) begin
      n_err++; $display("FAIL pre_reset_run: got rem=%0d cnt=%0d want rem=%0d cnt=%0d", remaining, step_count, m_rem, m_cnt);
    end
    #3 reset = 1;
    #1;
    model_reset();
    n_cmp++;
    if ({busy, step, remaining, step_count} !== '0) begin
      n_err++; $display("FAIL reset_mid_run: got busy=%0b step=%0b rem=%0d cnt=%0d want all 0", busy, step, remaining, step_count);
    end
    @(posedge clk); #1; reset = 0;
  endtask

  task automatic test_periodic();
    int exp_rem[10] = '{3, 2, 1, 3, 2, 1, 3, 2, 1, 3};
    bit exp_step;
    periodic = 1; period_us = 3; start = 1; tick = 1; cyc();
    for (int k = 1; k <= 10; k++) begin
      exp_step = (k == 4 || k == 7 || k == 10);
      n_cmp++;
      if (remaining !== CNT_W'(exp_rem[k-1]) || step !== exp_step) begin
        n_err++; $display("FAIL periodic_c%0d: got rem=%0d step=%0b want rem=%0d step=%0b", k, remaining, step, exp_rem[k-1], exp_step);
      end
      if (k < 10) begin tick = 1; cyc(); end
    end
    n_cmp++;
    if (step_count !== 8'd3) begin
      n_err++; $display("FAIL periodic_count: got %0d want 3", step_count);
    end
  endtask

  task automatic test_oneshot();
    int seen = 0;
    periodic = 0; period_us = 5; start = 1; cyc();
    for (int c = 0; c < 400; c++) begin
      tick = (c % 36 == 35);
      cyc();
      n_cmp++;
      if (remaining !== CNT_W'(m_rem) || busy !== m_run) begin
        n_err++; $display("FAIL oneshot_trace c%0d: got rem=%0d busy=%0b want rem=%0d busy=%0b", c, remaining, busy, m_rem, m_run);
      end
      if (step) begin
        seen++;
        n_cmp++;
        if (busy !== 1'b0 || remaining !== '0 || step_count !== 8'd1) begin
          n_err++; $display("FAIL oneshot_expiry: got busy=%0b rem=%0d cnt=%0d want 0/0/1", busy, remaining, step_count);
        end
      end
    end
    n_cmp++;
    if (seen != 1) begin
      n_err++; $display("FAIL oneshot_steps: got %0d want 1", seen);
    end
  endtask

  task automatic test_pause();
    periodic = 1; period_us = 4; start = 1; cyc();
    wait_tick(36); wait_tick(36);
    pause = 1; tick = 1; cyc();
    repeat (100) wait_tick(36);
    n_cmp++;
    if (remaining !== CNT_W'(2) || busy !== 1'b1 || step !== 1'b0) begin
      n_err++; $display("FAIL pause_hold: got rem=%0d busy=%0b step=%0b want 2/1/0", remaining, busy, step);
    end
    pause = 0; cyc();
    wait_tick(36);
    n_cmp++;
    if (remaining !== CNT_W'(1) || step !== 1'b0) begin
      n_err++; $display("FAIL pause_resume1: got rem=%0d step=%0b want 1/0", remaining, step);
    end
    wait_tick(36);
    n_cmp++;
    if (step !== 1'b1 || remaining !== CNT_W'(4) || step_count !== 8'd1) begin
      n_err++; $display("FAIL pause_resume2: got step=%0b rem=%0d cnt=%0d want 1/4/1", step, remaining, step_count);
    end
  endtask

  task automatic test_stop_start();
    stop = 1; start = 1; period_us = 7; cyc();
    n_cmp++;
    if (busy !== 1'b0 || step !== 1'b0 || remaining !== '0 || step_count !== 8'd1) begin
      n_err++; $display("FAIL stop_start: got busy=%0b step=%0b rem=%0d cnt=%0d want 0/0/0/1", busy, step, remaining, step_count);
    end
    start = 1; tick = 1; period_us = 9; cyc();
    n_cmp++;
    if (remaining !== CNT_W'(9) || busy !== 1'b1) begin
      n_err++; $display("FAIL start_tick: got rem=%0d busy=%0b want 9/1", remaining, busy);
    end
    start = 1; period_us = 0; cyc();
    n_cmp++;
    if (remaining !== CNT_W'(1) || step_count !== 8'd0) begin
      n_err++; $display("FAIL start_zero: got rem=%0d cnt=%0d want 1/0", remaining, step_count);
    end
    stop = 1; cyc();
    n_cmp++;
    if (busy !== 1'b0 || remaining !== '0) begin
      n_err++; $display("FAIL stop: got busy=%0b rem=%0d want 0/0", busy, remaining);
    end
  endtask

  task automatic test_wrap();
    int nsteps = 0;
    bit prev = 0;
    periodic = 1; period_us = 1; start = 1; cyc();
    for (int i = 1; i <= 256; i++) begin
      cyc();
      tick = 1; cyc();
      if (i == 255) begin
        n_cmp++;
        if (step_count !== 8'd255) begin
          n_err++; $display("FAIL wrap_255: got %0d want 255", step_count);
        end
      end
    end
    n_cmp++;
    if (step_count !== 8'd0 || step !== 1'b1) begin
      n_err++; $display("FAIL wrap_0: got cnt=%0d step=%0b want 0/1", step_count, step);
    end
    start = 1; cyc();
    for (int i = 0; i < 6; i++) begin
      tick = 1; cyc();
      if (step) nsteps++;
      n_cmp++;
      if (prev && step) begin
        n_err++; $display("FAIL step_double: got step high on consecutive cycles want single");
      end
      prev = step;
    end
    n_cmp++;
    if (nsteps != 3 || step_count !== 8'd3) begin
      n_err++; $display("FAIL back_to_back: got steps=%0d cnt=%0d want 3/3", nsteps, step_count);
    end
  endtask

  task automatic test_speedup();
    int exp_reload;
    exp_reload = SPEEDUP ? MIN_PERIOD : 3;
    periodic = 1; period_us = 3; start = 1; cyc();
    repeat (100) begin kill = 1; cyc(); end
    repeat (3) begin tick = 1; cyc(); end
    n_cmp++;
    if (step !== 1'b1 || remaining !== CNT_W'(exp_reload)) begin
      n_err++; $display("FAIL speedup_reload: got step=%0b rem=%0d want 1/%0d", step, remaining, exp_reload);
    end
    period_us = 30000; start = 1; kill = 1; cyc();
    repeat (29999) begin tick = 1; cyc(); end
    tick = 1; cyc();
    n_cmp++;
    if (step !== 1'b1 || remaining !== CNT_W'(30000)) begin
      n_err++; $display("FAIL kill_with_start: got step=%0b rem=%0d want 1/30000", step, remaining);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 59) == 0);
      stop  = ($urandom_range(0, 199) == 0);
      kill  = ($urandom_range(0, 39) == 0);
      tick  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 49) == 0) pause = ~pause;
      if (start) begin
        period_us = CNT_W'($urandom_range(0, 6));
        periodic  = $urandom_range(0, 1);
      end
      cyc();
      n_cmp++;
      if (busy !== m_run || step !== m_step || remaining !== CNT_W'(m_rem) || step_count !== 8'(m_cnt)) begin
        n_err++; $display("FAIL random c%0d: got busy=%0b step=%0b rem=%0d cnt=%0d want busy=%0b step=%0b rem=%0d cnt=%0d",
                          c, busy, step, remaining, step_count, m_run, m_step, m_rem, m_cnt);
      end
    end
    pause = 0;
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_pause();
    test_stop_start();
    test_wrap();
    test_speedup();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
